// File: rtl/filter_pkg.sv
// Shared constants and width helpers for the filter family. Downstream
// filter blocks import this so that sample and accumulator widths agree.
package filter_pkg;

  localparam int DEFAULT_DATA_W = 14;
  localparam int DEFAULT_DEPTH  = 10;

  // Width of an accumulator holding the sum of depth unsigned samples of
  // data_w bits each; depth * (2**data_w - 1) always fits in this width.
  function automatic int sum_width(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Tapped delay line with a running sum of all taps. Each accepted sample
// enters tap 0 and pushes the older samples one tap further; the sample that
// falls off the end is subtracted from the sum as the new one is added, so
// the sum tracks the window with a single add/subtract per sample.
module tap_delay_line
  import filter_pkg::*;
#(
  parameter int  DATA_W = DEFAULT_DATA_W,
  parameter int  DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int SUM_W  = sum_width(DATA_W, DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       data,
  input  logic                    flush,
  output logic [DEPTH*DATA_W-1:0] taps,
  output logic [SUM_W-1:0]        sum,
  output logic [CNT_W-1:0]        fill_count,
  output logic                    full,
  output logic                    out_valid
);

  // Reject parameterisations that make no sense for a delay line.
  if (DEPTH < 2) begin : g_bad_depth
    $error("tap_delay_line: DEPTH must be at least 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("tap_delay_line: DATA_W must be at least 1");
  end

  logic [DATA_W-1:0] line [DEPTH];
  logic              accept;
  logic [CNT_W-1:0]  count_next;

  // Flush wins over a simultaneous sample, which is then dropped.
  assign accept = in_valid & ~flush;

  assign full = (fill_count == CNT_W'(DEPTH));

  // The fill count saturates once the window has been filled.
  assign count_next = full ? fill_count : fill_count + CNT_W'(1);

  // Flatten the internal line onto the output port, tap 0 in the low bits.
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DATA_W +: DATA_W] = line[k];
  end

  // Shift register: new sample into tap 0, oldest sample discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        line[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        line[k] <= '0;
      end
    end else if (accept) begin
      line[0] <= data;
      for (int k = 1; k < DEPTH; k++) begin
        line[k] <= line[k-1];
      end
    end
  end

  // Running sum, fill count and the one-cycle full-window pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum        <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      sum        <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      sum        <= sum + SUM_W'(data) - SUM_W'(line[DEPTH-1]);
      fill_count <= count_next;
      out_valid  <= (count_next == CNT_W'(DEPTH));
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_delay_line.sv
// Self-checking bench for tap_delay_line. A default-sized instance is driven
// with directed and random traffic and compared to a queue-based window
// model; a small 8-bit, 4-tap instance checks the narrow-width corner.
module tb_tap_delay_line;

  localparam int A_W     = 14;
  localparam int A_D     = 10;
  localparam int A_CNT_W = $clog2(A_D + 1);
  localparam int A_SUM_W = A_W + $clog2(A_D);
  localparam int B_W     = 8;
  localparam int B_D     = 4;
  localparam int B_CNT_W = $clog2(B_D + 1);
  localparam int B_SUM_W = B_W + $clog2(B_D);

  logic clk = 1'b0;
  logic reset;

  logic                   a_in_valid;
  logic [A_W-1:0]         a_data;
  logic                   a_flush;
  logic [A_D*A_W-1:0]     a_taps;
  logic [A_SUM_W-1:0]     a_sum;
  logic [A_CNT_W-1:0]     a_fill_count;
  logic                   a_full;
  logic                   a_out_valid;

  logic                   b_in_valid;
  logic [B_W-1:0]         b_data;
  logic                   b_flush;
  logic [B_D*B_W-1:0]     b_taps;
  logic [B_SUM_W-1:0]     b_sum;
  logic [B_CNT_W-1:0]     b_fill_count;
  logic                   b_full;
  logic                   b_out_valid;

  int tests = 0;
  int fails = 0;

  // Reference model: the window as a queue, newest sample at the front.
  int unsigned model_q[$];
  int          model_cnt;
  bit          model_ov;

  always #5 clk = ~clk;

  tap_delay_line dut_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (a_in_valid),
    .data       (a_data),
    .flush      (a_flush),
    .taps       (a_taps),
    .sum        (a_sum),
    .fill_count (a_fill_count),
    .full       (a_full),
    .out_valid  (a_out_valid)
  );

  tap_delay_line #(.DATA_W(B_W), .DEPTH(B_D)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (b_in_valid),
    .data       (b_data),
    .flush      (b_flush),
    .taps       (b_taps),
    .sum        (b_sum),
    .fill_count (b_fill_count),
    .full       (b_full),
    .out_valid  (b_out_valid)
  );

  task automatic modelClear();
    model_q.delete();
    for (int k = 0; k < A_D; k++) model_q.push_back(0);
    model_cnt = 0;
    model_ov  = 1'b0;
  endtask

  task automatic modelStep(input bit v, input int unsigned d, input bit f);
    if (f) begin
      modelClear();
    end else if (v) begin
      model_q.push_front(d);
      void'(model_q.pop_back());
      model_cnt = (model_cnt + 1 > A_D) ? A_D : model_cnt + 1;
      model_ov  = (model_cnt == A_D);
    end else begin
      model_ov = 1'b0;
    end
  endtask

  task automatic checkValue(input string tag, input longint got, input longint expected);
    tests++;
    assert (got === expected) else begin
      fails++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
    end
  endtask

  // Compare every output of the default instance against the model.
  task automatic checkOutput(input string tag);
    logic [A_D*A_W-1:0] exp_taps;
    longint             exp_sum;
    exp_sum = 0;
    for (int k = 0; k < A_D; k++) begin
      exp_taps[k*A_W +: A_W] = A_W'(model_q[k]);
      exp_sum += model_q[k];
    end
    tests++;
    assert (a_taps === exp_taps) else begin
      fails++;
      $error("[TB] FAIL %s taps: got %h expected %h", tag, a_taps, exp_taps);
    end
    tests++;
    assert (a_sum === A_SUM_W'(exp_sum)) else begin
      fails++;
      $error("[TB] FAIL %s sum: got %0d expected %0d", tag, a_sum, exp_sum);
    end
    tests++;
    assert (a_fill_count === A_CNT_W'(model_cnt)) else begin
      fails++;
      $error("[TB] FAIL %s fill_count: got %0d expected %0d", tag, a_fill_count, model_cnt);
    end
    tests++;
    assert (a_full === (model_cnt == A_D)) else begin
      fails++;
      $error("[TB] FAIL %s full: got %0b expected %0b", tag, a_full, model_cnt == A_D);
    end
    tests++;
    assert (a_out_valid === model_ov) else begin
      fails++;
      $error("[TB] FAIL %s out_valid: got %0b expected %0b", tag, a_out_valid, model_ov);
    end
  endtask

  // Drive one cycle on the default instance, then check just after the edge.
  task automatic applyStimulus(input bit v, input int unsigned d, input bit f, input string tag);
    a_in_valid = v;
    a_data     = A_W'(d);
    a_flush    = f;
    @(posedge clk);
    modelStep(v, d, f);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyRandom(input int cycles, input int flush_pct);
    bit          v;
    bit          f;
    int unsigned d;
    for (int i = 0; i < cycles; i++) begin
      v = ($urandom_range(99) < 70);
      f = ($urandom_range(99) < flush_pct);
      d = $urandom_range((1 << A_W) - 1);
      applyStimulus(v, d, f, "random");
    end
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    a_in_valid = 1'b0;
    a_data     = '0;
    a_flush    = 1'b0;
    b_in_valid = 1'b0;
    b_data     = '0;
    b_flush    = 1'b0;
    modelClear();

    // Reset state, including a sample presented on an edge while in reset.
    #3;
    checkOutput("reset");
    a_in_valid = 1'b1;
    a_data     = 14'd999;
    @(posedge clk);
    #1;
    checkOutput("reset_edge");
    a_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Narrow instance: four full-scale samples give 1020 on a 10-bit sum.
    for (int i = 1; i <= B_D; i++) begin
      b_in_valid = 1'b1;
      b_data     = 8'd255;
      @(posedge clk);
      #1;
      checkValue("b_out_valid", b_out_valid, (i == B_D) ? 1 : 0);
      checkValue("b_fill_count", b_fill_count, i);
    end
    b_in_valid = 1'b0;
    checkValue("b_sum", b_sum, 1020);
    checkValue("b_full", b_full, 1);
    @(posedge clk);
    #1;
    checkValue("b_out_valid_drop", b_out_valid, 0);
    checkValue("b_sum_hold", b_sum, 1020);

    // Samples 1..10: first full window.
    for (int i = 1; i <= A_D; i++) applyStimulus(1'b1, i, 1'b0, "ramp");
    checkValue("ramp_sum", a_sum, 55);
    checkValue("ramp_tap0", a_taps[0 +: A_W], 10);
    checkValue("ramp_tap9", a_taps[9*A_W +: A_W], 1);
    checkValue("ramp_fill", a_fill_count, 10);
    checkValue("ramp_ov", a_out_valid, 1);

    // Sample 11, then a five-cycle stall.
    applyStimulus(1'b1, 11, 1'b0, "eleven");
    checkValue("eleven_sum", a_sum, 65);
    checkValue("eleven_tap9", a_taps[9*A_W +: A_W], 2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 12345, 1'b0, "stall");
    checkValue("stall_sum", a_sum, 65);

    // Full-scale samples exercise the widest sum.
    for (int i = 0; i < A_D; i++) applyStimulus(1'b1, 16383, 1'b0, "max");
    checkValue("max_sum", a_sum, 163830);
    applyStimulus(1'b1, 0, 1'b0, "max_drop");
    checkValue("max_drop_sum", a_sum, 147447);

    // Flush after four samples, with a competing sample that must be dropped.
    applyStimulus(1'b1, 0, 1'b1, "flush_pre");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 100 + i, 1'b0, "partial");
    applyStimulus(1'b1, 7, 1'b1, "flush");
    checkValue("flush_sum", a_sum, 0);
    checkValue("flush_fill", a_fill_count, 0);
    checkValue("flush_full", a_full, 0);

    // Window fills across idle gaps.
    for (int i = 0; i < A_D; i++) begin
      applyStimulus(1'b0, 0, 1'b0, "gap_idle");
      applyStimulus(1'b1, 200 + i, 1'b0, "gap_data");
    end
    checkValue("gap_ov", a_out_valid, 1);

    applyRandom(80, 5);

    // Asynchronous reset between edges mid-stream.
    for (int i = 0; i < A_D + 3; i++) applyStimulus(1'b1, $urandom_range(16383), 1'b0, "prefill");
    #2;
    reset = 1'b1;
    #1;
    modelClear();
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    checkOutput("async_reset_hold");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < A_D; i++) begin
      applyStimulus(1'b1, $urandom_range(16383), 1'b0, "refill");
      if (i % 3 == 1) applyStimulus(1'b0, 0, 1'b0, "refill_idle");
    end
    checkValue("refill_ov", a_out_valid, 1);

    applyRandom(80, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
